usb_reg_initiator: RTL and testbench

Bus-master end of the ChipWhisperer parallel register bus: turns byte-burst commands into address, chip-enable, address-latch, read and write strobes on the cwusb_* pins. It implements the microcontroller side of the bus that the FPGA register responder decodes. Use cases are on-FPGA loopback/self-test and driving the responder from a simulation bench as synthesizable RTL. A write burst moves N bytes from a write stream onto the bus; a read burst captures N bytes from the bus into a read stream.

---
 rtl/usb_reg_pkg.sv | 28 ++
 rtl/usb_phase_timer.sv | 37 +++
 rtl/usb_reg_initiator.sv | 241 ++++++++++++++++++++++++
 tb/tb_usb_reg_initiator.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_reg_pkg.sv
// Shared state encoding and timing floors for the ChipWhisperer
// register-bus initiator (usb_reg_initiator).
package usb_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT_WR,
    STROBE,
    HOLD,
    END
  } usb_state_e;

  localparam int MIN_SETUP_CYCLES  = 1;
  localparam int MIN_STROBE_CYCLES = 3;
  localparam int MIN_HOLD_CYCLES   = 3;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/usb_phase_timer.sv
// Loadable down-counter; done is high once the count reaches zero.
// Loading N-1 on entry gives a phase that lasts exactly N cycles.
module usb_phase_timer
  import usb_reg_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/usb_reg_initiator.sv
// Bus-master side of the ChipWhisperer parallel register bus.
// Define USB_INIT_CONTENTION_CHECK_EN to add the sticky contention_err output.
module usb_reg_initiator
  import usb_reg_pkg::*;
#(
  parameter int pBYTECNT_SIZE  = 7,
  parameter int pSETUP_CYCLES  = 2,
  parameter int pSTROBE_CYCLES = 4,
  parameter int pHOLD_CYCLES   = 3
) (
  input  logic                     clk_usb,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [7:0]               cmd_addr,
  input  logic [pBYTECNT_SIZE-1:0] cmd_len,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic                     busy,
`ifdef USB_INIT_CONTENTION_CHECK_EN
  output logic                     contention_err,
`endif
  output logic [7:0]               cwusb_addr,
  output logic [7:0]               cwusb_dout,
  output logic                     cwusb_oe,
  input  logic [7:0]               cwusb_din,
  input  logic                     cwusb_isout,
  output logic                     cwusb_rdn,
  output logic                     cwusb_wrn,
  output logic                     cwusb_cen,
  output logic                     cwusb_alen
);

  localparam int PMAX = max3(pSETUP_CYCLES, pSTROBE_CYCLES, pHOLD_CYCLES);
  localparam int PW = $clog2(PMAX) + 1;
  localparam int BW = pBYTECNT_SIZE;
  localparam logic [BW-1:0] BC_ONE = BW'(1);

  if (pSETUP_CYCLES < MIN_SETUP_CYCLES ||
      pSTROBE_CYCLES < MIN_STROBE_CYCLES ||
      pHOLD_CYCLES < MIN_HOLD_CYCLES) begin : g_bad_timing
    $error("usb_reg_initiator: timing parameter below minimum");
  end

  usb_state_e state_q, state_d;
  logic          write_q, write_d;
  logic [BW-1:0] remaining_q, remaining_d;
  logic [7:0]    addr_q, addr_d;
  logic          have_byte_q, have_byte_d;
  logic [7:0]    dout_q, dout_d;
  logic          oe_q, oe_d;
  logic          rdn_q, rdn_d;
  logic          wrn_q, wrn_d;
  logic          cen_q, cen_d;
  logic          alen_q, alen_d;
  logic          wr_ready_q, wr_ready_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          busy_q, busy_d;
  logic          cmd_ready_q, cmd_ready_d;

  logic          timer_load;
  logic [PW-1:0] timer_val;
  logic          timer_done;
  logic          in_burst;
  logic          capture;
  logic          rd_fire;

  usb_phase_timer #(
    .W(PW)
  ) u_timer (
    .clk      (clk_usb),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk_usb) begin
    if (reset) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      remaining_q <= '0;
      addr_q      <= 8'h00;
      have_byte_q <= 1'b0;
      dout_q      <= 8'h00;
      oe_q        <= 1'b0;
      rdn_q       <= 1'b1;
      wrn_q       <= 1'b1;
      cen_q       <= 1'b1;
      alen_q      <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      have_byte_q <= have_byte_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      rdn_q       <= rdn_d;
      wrn_q       <= wrn_d;
      cen_q       <= cen_d;
      alen_q      <= alen_d;
      wr_ready_q  <= wr_ready_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    have_byte_d = have_byte_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = SETUP;
          write_d     = cmd_write;
          addr_d      = cmd_addr;
          remaining_d = (cmd_len == '0) ? BC_ONE : cmd_len;
        end
      end
      SETUP: begin
        if (timer_done) begin
          state_d = write_q ? WAIT_WR : STROBE;
        end
      end
      WAIT_WR: begin
        // one cycle of dout set-up before wrn falls
        if (have_byte_q) begin
          state_d     = STROBE;
          have_byte_d = 1'b0;
        end else if (wr_valid) begin
          have_byte_d = 1'b1;
        end
      end
      STROBE: begin
        if (timer_done) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (timer_done) begin
          if (remaining_q != '0) begin
            remaining_d = remaining_q - 1'b1;
          end
          if (remaining_q > BC_ONE) begin
            state_d = write_q ? WAIT_WR : STROBE;
          end else begin
            state_d = END;
          end
        end
      end
      END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from state_d so they line up with state_q.
  always_comb begin
    in_burst = (state_d == SETUP) || (state_d == WAIT_WR) ||
               (state_d == STROBE) || (state_d == HOLD);
    cen_d  = !in_burst;
    alen_d = (state_d != SETUP);
    rdn_d  = !((state_d == STROBE) && !write_q);
    wrn_d  = !((state_d == STROBE) && write_q);

    capture    = (state_q == WAIT_WR) && !have_byte_q && wr_valid;
    wr_ready_d = capture;
    dout_d     = capture ? wr_data : dout_q;
    oe_d       = (in_burst && oe_q) || capture;

    rd_fire    = (state_q == STROBE) && timer_done && !write_q;
    rd_valid_d = rd_fire;
    rd_data_d  = rd_fire ? cwusb_din : rd_data_q;

    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE);

    timer_load = (state_d != state_q);
    unique case (state_d)
      SETUP:   timer_val = PW'(pSETUP_CYCLES - 1);
      STROBE:  timer_val = PW'(pSTROBE_CYCLES - 1);
      HOLD:    timer_val = PW'(pHOLD_CYCLES - 1);
      default: timer_val = '0;
    endcase
  end

`ifdef USB_INIT_CONTENTION_CHECK_EN
  logic contention_q;
  logic contention_d;

  always_comb begin
    contention_d = contention_q | (oe_q & cwusb_isout);
  end

  always_ff @(posedge clk_usb) begin
    if (reset) begin
      contention_q <= 1'b0;
    end else begin
      contention_q <= contention_d;
    end
  end

  assign contention_err = contention_q;
`else
  logic unused_isout;
  assign unused_isout = cwusb_isout;
`endif

  assign cmd_ready  = cmd_ready_q;
  assign wr_ready   = wr_ready_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = busy_q;
  assign cwusb_addr = addr_q;
  assign cwusb_dout = dout_q;
  assign cwusb_oe   = oe_q;
  assign cwusb_rdn  = rdn_q;
  assign cwusb_wrn  = wrn_q;
  assign cwusb_cen  = cen_q;
  assign cwusb_alen = alen_q;

endmodule

// File: tb/tb_usb_reg_initiator.sv
// Self-checking bench for usb_reg_initiator with a behavioural
// responder model and write/read scoreboards.
module tb_usb_reg_initiator;

  logic       clk_usb = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [6:0] cmd_len = 7'd0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic [7:0] cwusb_addr;
  logic [7:0] cwusb_dout;
  logic       cwusb_oe;
  logic [7:0] cwusb_din;
  logic       cwusb_isout = 1'b0;
  logic       cwusb_rdn;
  logic       cwusb_wrn;
  logic       cwusb_cen;
  logic       cwusb_alen;
`ifdef USB_INIT_CONTENTION_CHECK_EN
  logic       contention_err;
`endif

  usb_reg_initiator dut (
    .clk_usb        (clk_usb),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .wr_data        (wr_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .busy           (busy),
`ifdef USB_INIT_CONTENTION_CHECK_EN
    .contention_err (contention_err),
`endif
    .cwusb_addr     (cwusb_addr),
    .cwusb_dout     (cwusb_dout),
    .cwusb_oe       (cwusb_oe),
    .cwusb_din      (cwusb_din),
    .cwusb_isout    (cwusb_isout),
    .cwusb_rdn      (cwusb_rdn),
    .cwusb_wrn      (cwusb_wrn),
    .cwusb_cen      (cwusb_cen),
    .cwusb_alen     (cwusb_alen)
  );

  always #5 clk_usb = ~clk_usb;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] cnt;
  } wr_exp_t;

  wr_exp_t    exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] wr_src_q[$];

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rd_base = 8'h10;
  logic [7:0] bcnt = 8'h00;
  assign cwusb_din = rd_base + bcnt;

  logic       prev_wrn = 1'b1;
  logic       prev_rdn = 1'b1;
  logic       prev_alen = 1'b1;
  logic [7:0] prev_dout = 8'h00;
  logic [7:0] held_dout = 8'h00;
  logic [7:0] held_addr = 8'h00;
  int wrn_low = 0;
  int rdn_low = 0;
  int alen_low = 0;
  int hold_left = 0;
  int alen_periods = 0;
  int wr_ready_pulses = 0;
  int rd_events = 0;

  task automatic tick();
    @(posedge clk_usb);
    #1;
  endtask

  // Responder model plus scoreboard consumer, sampled on falling edges.
  task automatic monitor();
    wr_exp_t    e;
    logic [7:0] r;
    forever begin
      @(negedge clk_usb);
      if (reset) begin
        bcnt = 8'h00;
        wrn_low = 0;
        rdn_low = 0;
        alen_low = 0;
        hold_left = 0;
      end else begin
        if (!cwusb_alen) begin
          if (prev_alen) alen_periods++;
          alen_low++;
          bcnt = 8'h00;
        end else if (!prev_alen) begin
          vectors++;
          if (alen_low !== 2) begin
            miscompares++;
            $display("FAIL alen_low_cycles: got %0d want 2", alen_low);
          end
          alen_low = 0;
        end
        if (!cwusb_wrn && prev_wrn) begin
          vectors++;
          if (exp_wr.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: addr %h data %h", cwusb_addr, cwusb_dout);
          end else begin
            e = exp_wr.pop_front();
            if (cwusb_addr !== e.addr || cwusb_dout !== e.data ||
                bcnt !== e.cnt || prev_dout !== e.data || cwusb_oe !== 1'b1) begin
              miscompares++;
              $display("FAIL reg_write: got addr %h data %h cnt %0d pre %h oe %b want addr %h data %h cnt %0d oe 1",
                       cwusb_addr, cwusb_dout, bcnt, prev_dout, cwusb_oe, e.addr, e.data, e.cnt);
            end
          end
        end
        if (!cwusb_wrn) begin
          wrn_low++;
        end else if (!prev_wrn) begin
          vectors++;
          if (wrn_low !== 4) begin
            miscompares++;
            $display("FAIL wrn_low_cycles: got %0d want 4", wrn_low);
          end
          wrn_low = 0;
          hold_left = 3;
          held_dout = cwusb_dout;
          held_addr = cwusb_addr;
          bcnt = bcnt + 8'h01;
        end
        if (!cwusb_rdn) begin
          rdn_low++;
        end else if (!prev_rdn) begin
          vectors++;
          if (rdn_low !== 4) begin
            miscompares++;
            $display("FAIL rdn_low_cycles: got %0d want 4", rdn_low);
          end
          rdn_low = 0;
          bcnt = bcnt + 8'h01;
        end
        if (hold_left > 0) begin
          vectors++;
          if (cwusb_dout !== held_dout || cwusb_addr !== held_addr ||
              cwusb_cen !== 1'b0 || cwusb_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL write_hold: got dout %h addr %h cen %b oe %b want dout %h addr %h cen 0 oe 1",
                     cwusb_dout, cwusb_addr, cwusb_cen, cwusb_oe, held_dout, held_addr);
          end
          hold_left--;
        end
        if (wr_ready) wr_ready_pulses++;
        if (rd_valid) begin
          rd_events++;
          vectors++;
          if (exp_rd.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_rd_valid: data %h", rd_data);
          end else begin
            r = exp_rd.pop_front();
            if (rd_data !== r) begin
              miscompares++;
              $display("FAIL rd_data: got %h want %h", rd_data, r);
            end
          end
        end
      end
      prev_wrn  = cwusb_wrn;
      prev_rdn  = cwusb_rdn;
      prev_alen = cwusb_alen;
      prev_dout = cwusb_dout;
    end
  endtask

  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [6:0] l);
    int t;
    t = 0;
    while (!cmd_ready && t < 200) begin
      tick();
      t++;
    end
    vectors++;
    if (t >= 200) begin
      miscompares++;
      $display("FAIL cmd_ready_timeout: got 0 want 1");
    end
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input int stall_idx, input int stall_len);
    int idx;
    int t;
    idx = 0;
    while (wr_src_q.size() > 0) begin
      if (idx == stall_idx) begin
        wr_valid = 1'b0;
        repeat (stall_len) tick();
        @(negedge clk_usb);
        vectors++;
        if (cwusb_cen !== 1'b0 || cwusb_wrn !== 1'b1 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL stall_state: got cen %b wrn %b busy %b want cen 0 wrn 1 busy 1",
                   cwusb_cen, cwusb_wrn, busy);
        end
        tick();
      end
      wr_data  = wr_src_q.pop_front();
      wr_valid = 1'b1;
      t = 0;
      do begin
        tick();
        t++;
      end while (!wr_ready && t < 100);
      vectors++;
      if (t >= 100) begin
        miscompares++;
        $display("FAIL wr_ready_timeout: got 0 want 1");
      end
      tick();
      wr_valid = 1'b0;
      idx++;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || !cmd_ready) && t < 500) begin
      tick();
      t++;
    end
    vectors++;
    if (t >= 500) begin
      miscompares++;
      $display("FAIL idle_timeout: got busy %b want 0", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clk_usb);
    vectors++;
    if ({cwusb_rdn, cwusb_wrn, cwusb_cen, cwusb_alen, cwusb_oe, cwusb_addr,
         cwusb_dout, rd_valid, wr_ready, busy, cmd_ready} !==
        {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdn %b wrn %b cen %b alen %b oe %b addr %h dout %h rv %b wr %b busy %b rdy %b",
               cwusb_rdn, cwusb_wrn, cwusb_cen, cwusb_alen, cwusb_oe, cwusb_addr,
               cwusb_dout, rd_valid, wr_ready, busy, cmd_ready);
    end
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk_usb);
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_ready: got rdy %b busy %b want rdy 1 busy 0", cmd_ready, busy);
    end
  endtask

  task automatic check_burst(input string name, input int pulses0, input int want_pulses,
                             input int ap0);
    vectors++;
    if (wr_ready_pulses - pulses0 !== want_pulses || exp_wr.size() !== 0 ||
        alen_periods - ap0 !== 1) begin
      miscompares++;
      $display("FAIL %s: got wr_ready %0d pending %0d alen_periods %0d want %0d 0 1",
               name, wr_ready_pulses - pulses0, exp_wr.size(), alen_periods - ap0, want_pulses);
    end
  endtask

  task automatic test_single_write();
    int p0;
    int a0;
    p0 = wr_ready_pulses;
    a0 = alen_periods;
    exp_wr.push_back({8'h1A, 8'hA5, 8'h00});
    wr_src_q.push_back(8'hA5);
    send_cmd(1'b1, 8'h1A, 7'd1);
    feed(-1, 0);
    wait_idle();
    check_burst("single_write", p0, 1, a0);
  endtask

  task automatic test_read_burst();
    int a0;
    int r0;
    a0 = alen_periods;
    r0 = rd_events;
    rd_base = 8'h10;
    for (int i = 0; i < 4; i++) exp_rd.push_back(8'h10 + 8'(i));
    send_cmd(1'b0, 8'h03, 7'd4);
    wait_idle();
    vectors++;
    if (rd_events - r0 !== 4 || exp_rd.size() !== 0 || alen_periods - a0 !== 1 ||
        bcnt !== 8'd4) begin
      miscompares++;
      $display("FAIL read_burst: got rd %0d pending %0d alen_periods %0d bcnt %0d want 4 0 1 4",
               rd_events - r0, exp_rd.size(), alen_periods - a0, bcnt);
    end
  endtask

  task automatic test_write_stall();
    int p0;
    int a0;
    p0 = wr_ready_pulses;
    a0 = alen_periods;
    for (int i = 0; i < 3; i++) begin
      exp_wr.push_back({8'h55, 8'hC1 + 8'(i), 8'(i)});
      wr_src_q.push_back(8'hC1 + 8'(i));
    end
    send_cmd(1'b1, 8'h55, 7'd3);
    feed(1, 9);
    wait_idle();
    check_burst("write_stall", p0, 3, a0);
  endtask

  task automatic test_len_zero();
    int p0;
    int a0;
    p0 = wr_ready_pulses;
    a0 = alen_periods;
    exp_wr.push_back({8'h44, 8'h5C, 8'h00});
    wr_src_q.push_back(8'h5C);
    send_cmd(1'b1, 8'h44, 7'd0);
    feed(-1, 0);
    wait_idle();
    check_burst("len_zero", p0, 1, a0);
    repeat (3) tick();
    vectors++;
    if (busy !== 1'b0 || cwusb_cen !== 1'b1) begin
      miscompares++;
      $display("FAIL len_zero_idle: got busy %b cen %b want 0 1", busy, cwusb_cen);
    end
  endtask

  task automatic test_reset_mid_read();
    int t;
    rd_base = 8'h20;
    send_cmd(1'b0, 8'h07, 7'd4);
    t = 0;
    while (cwusb_rdn && t < 100) begin
      tick();
      t++;
    end
    vectors++;
    if (t >= 100) begin
      miscompares++;
      $display("FAIL rdn_timeout: got 1 want 0");
    end
    tick();
    reset = 1'b1;
    tick();
    vectors++;
    if ({cwusb_rdn, cwusb_cen, cwusb_alen, cwusb_oe, rd_valid, busy} !==
        {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_read_reset: got rdn %b cen %b alen %b oe %b rv %b busy %b want 1 1 1 0 0 0",
               cwusb_rdn, cwusb_cen, cwusb_alen, cwusb_oe, rd_valid, busy);
    end
    tick();
    reset = 1'b0;
    tick();
    exp_rd.push_back(8'h20);
    send_cmd(1'b0, 8'h08, 7'd1);
    wait_idle();
    vectors++;
    if (exp_rd.size() !== 0) begin
      miscompares++;
      $display("FAIL read_after_reset: got pending %0d want 0", exp_rd.size());
    end
  endtask

`ifdef USB_INIT_CONTENTION_CHECK_EN
  task automatic test_contention();
    int t;
    vectors++;
    if (contention_err !== 1'b0) begin
      miscompares++;
      $display("FAIL contention_initial: got %b want 0", contention_err);
    end
    exp_wr.push_back({8'h60, 8'h77, 8'h00});
    wr_src_q.push_back(8'h77);
    send_cmd(1'b1, 8'h60, 7'd1);
    fork
      feed(-1, 0);
      begin
        t = 0;
        while (cwusb_wrn && t < 100) begin
          tick();
          t++;
        end
        cwusb_isout = 1'b1;
        tick();
        cwusb_isout = 1'b0;
      end
    join
    wait_idle();
    repeat (4) tick();
    vectors++;
    if (contention_err !== 1'b1) begin
      miscompares++;
      $display("FAIL contention_sticky: got %b want 1", contention_err);
    end
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if (contention_err !== 1'b0) begin
      miscompares++;
      $display("FAIL contention_clear: got %b want 0", contention_err);
    end
    reset = 1'b0;
    tick();
    tick();
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_write();
    test_read_burst();
    test_write_stall();
    test_len_zero();
    test_reset_mid_read();
`ifdef USB_INIT_CONTENTION_CHECK_EN
    test_contention();
`endif
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
